// File: rtl/i2s_pkg.sv
// Shared I2S timing parameters and word-select encoding.
// The transmitter and the receiver both import this package, so both ends agree on frame timing.
package i2s_pkg;

    // Audio sample width in bits
    localparam int I2S_WORD_WIDTH = 16;

    // SCK periods per channel slot
    localparam int I2S_SLOT_WIDTH = 32;

    // clk cycles per SCK half-period (27 MHz / 10 = 2.7 MHz SCK)
    localparam int I2S_SCK_HALF   = 5;

    // Word-select levels as seen on the WS pin
    typedef enum logic {
        I2S_WS_LEFT  = 1'b0,
        I2S_WS_RIGHT = 1'b1
    } i2s_ws_e;

endpackage

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock divider.
// Toggles SCK every SCK_HALF clk cycles. fall_event is high for one clk in the cycle
// whose closing edge takes SCK from 1 to 0, so that registers clocked on that edge
// change together with the SCK fall.
module i2s_sck_gen
    import i2s_pkg::*;
#(
    parameter int SCK_HALF = I2S_SCK_HALF
) (
    input  logic clk,
    input  logic reset,
    output logic sck,
    output logic fall_event
);

    localparam int DIV_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sck_q, sck_d;

    // Advance the divider and flip SCK at terminal count
    always_comb begin
        div_d = div_q + 1'b1;
        sck_d = sck_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            sck_d = ~sck_q;
        end
    end

    // Divider and SCK registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck        = sck_q;
    assign fall_event = (div_q == DIV_LAST) && sck_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: accepts stereo pairs into a one-deep holding register and
// serialises them MSB first with a one-SCK delay after each WS edge.
// Unused slot bits are zero-padded. A frame with no held pair sends silence and flags underrun.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int WORD_WIDTH = I2S_WORD_WIDTH,
    parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
    parameter int SCK_HALF   = I2S_SCK_HALF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] sample_left,
    input  logic [WORD_WIDTH-1:0] sample_right,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  SCK,
    output logic                  WS,
    output logic                  SD,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int CNT_W = $clog2(2 * SLOT_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [CNT_W-1:0] LEFT_LAST   = CNT_W'(WORD_WIDTH);
    localparam logic [CNT_W-1:0] RIGHT_START = CNT_W'(SLOT_WIDTH);
    localparam logic [CNT_W-1:0] RIGHT_FIRST = CNT_W'(SLOT_WIDTH + 1);
    localparam logic [CNT_W-1:0] RIGHT_LAST  = CNT_W'(SLOT_WIDTH + WORD_WIDTH);

    logic                  sck;
    logic                  fall_event;

    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_next;
    i2s_ws_e               ws_q, ws_d;
    logic                  sd_q, sd_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underrun_q, underrun_d;
    logic                  hold_full_q, hold_full_d;
    logic [WORD_WIDTH-1:0] hold_left_q, hold_left_d;
    logic [WORD_WIDTH-1:0] hold_right_q, hold_right_d;
    logic [WORD_WIDTH-1:0] shift_left_q, shift_left_d;
    logic [WORD_WIDTH-1:0] shift_right_q, shift_right_d;
    logic                  accept;

    i2s_sck_gen #(
        .SCK_HALF(SCK_HALF)
    ) u_sck_gen (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .fall_event(fall_event)
    );

    assign cnt_next = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    assign accept   = sample_valid && !hold_full_q;

    // Holding-register capture, frame load and per-fall serialisation of WS/SD
    always_comb begin
        cnt_d         = cnt_q;
        ws_d          = ws_q;
        sd_d          = sd_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        hold_full_d   = hold_full_q;
        hold_left_d   = hold_left_q;
        hold_right_d  = hold_right_q;
        shift_left_d  = shift_left_q;
        shift_right_d = shift_right_q;

        if (accept) begin
            hold_full_d  = 1'b1;
            hold_left_d  = sample_left;
            hold_right_d = sample_right;
        end

        if (fall_event) begin
            cnt_d = cnt_next;
            ws_d  = (cnt_next >= RIGHT_START) ? I2S_WS_RIGHT : I2S_WS_LEFT;
            sd_d  = 1'b0;
            if (cnt_next == '0) begin
                frame_start_d = 1'b1;
                if (hold_full_q) begin
                    shift_left_d  = hold_left_q;
                    shift_right_d = hold_right_q;
                    hold_full_d   = 1'b0;
                end else begin
                    shift_left_d  = '0;
                    shift_right_d = '0;
                    underrun_d    = 1'b1;
                end
            end else if (cnt_next <= LEFT_LAST) begin
                sd_d         = shift_left_q[WORD_WIDTH-1];
                shift_left_d = {shift_left_q[WORD_WIDTH-2:0], 1'b0};
            end else if ((cnt_next >= RIGHT_FIRST) && (cnt_next <= RIGHT_LAST)) begin
                sd_d          = shift_right_q[WORD_WIDTH-1];
                shift_right_d = {shift_right_q[WORD_WIDTH-2:0], 1'b0};
            end
        end
    end

    // State registers; reset parks the bit counter on its last count so the first fall loads a frame
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q         <= CNT_LAST;
            ws_q          <= I2S_WS_LEFT;
            sd_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_left_q   <= '0;
            hold_right_q  <= '0;
            shift_left_q  <= '0;
            shift_right_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            ws_q          <= ws_d;
            sd_q          <= sd_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            hold_full_q   <= hold_full_d;
            hold_left_q   <= hold_left_d;
            hold_right_q  <= hold_right_d;
            shift_left_q  <= shift_left_d;
            shift_right_q <= shift_right_d;
        end
    end

    assign sample_ready = ~hold_full_q;
    assign SCK          = sck;
    assign WS           = ws_q;
    assign SD           = sd_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Testbench for i2s_transmitter: a frame-level reference model checked on every
// clk, plus directed scenarios with hand-computed literal expectations.
module tb_i2s_transmitter;
    import i2s_pkg::*;

    localparam int W     = I2S_WORD_WIDTH;
    localparam int S     = I2S_SLOT_WIDTH;
    localparam int H     = I2S_SCK_HALF;
    localparam int FRAME = 2 * S * 2 * H;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] sample_left = '0;
    logic [W-1:0] sample_right = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic         SCK;
    logic         WS;
    logic         SD;
    logic         frame_start;
    logic         underrun;

    int compared = 0;
    int mismatched = 0;
    bit checkEn = 0;
    int tbEdges = 0;

    // Reference model state: edges since release, latest bit count, held and current frame
    int       mN = 0;
    bit       mFallen = 0;
    int       mBit = 2 * S - 1;
    bit       mHoldFull = 0;
    bit       mAcc = 0;
    logic [W-1:0] mHoldL = '0, mHoldR = '0, mFrameL = '0, mFrameR = '0;
    bit       mFs = 0, mUr = 0;

    logic [2*S-1:0] sdCap, wsCap;
    int             at;

    i2s_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .sample_left (sample_left),
        .sample_right(sample_right),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .SCK         (SCK),
        .WS          (WS),
        .SD          (SD),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    // 10 ns clk period
    always #5 clk = ~clk;

    // Edge counter since reset release, used for literal timing checks
    always @(posedge clk) begin
        if (!reset) tbEdges <= 0;
        else        tbEdges <= tbEdges + 1;
    end

    // Reference model: derives frame timing from the edge count and queues pairs in a one-deep hold
    always @(posedge clk) begin
        if (!reset) begin
            mN = 0; mFallen = 0; mBit = 2 * S - 1; mHoldFull = 0;
            mHoldL = '0; mHoldR = '0; mFrameL = '0; mFrameR = '0;
            mFs = 0; mUr = 0;
        end else begin
            mAcc = sample_valid && !mHoldFull;
            mN = mN + 1;
            mFs = 0;
            mUr = 0;
            if (mN % (2 * H) == 0) begin
                mFallen = 1;
                mBit = ((mN / (2 * H)) - 1) % (2 * S);
                if (mBit == 0) begin
                    mFs = 1;
                    if (mHoldFull) begin
                        mFrameL = mHoldL; mFrameR = mHoldR; mHoldFull = 0;
                    end else begin
                        mFrameL = '0; mFrameR = '0; mUr = 1;
                    end
                end
            end
            if (mAcc) begin
                mHoldL = sample_left; mHoldR = sample_right; mHoldFull = 1;
            end
        end
    end

    function automatic logic expSd();
        if (!mFallen) return 1'b0;
        if (mBit >= 1 && mBit <= W) return mFrameL[W - mBit];
        if (mBit >= S + 1 && mBit <= S + W) return mFrameR[S + W - mBit];
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model, away from the active edge
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("SCK", {31'b0, SCK}, {31'b0, ((mN / H) % 2) == 1});
            checkOutput("WS", {31'b0, WS}, {31'b0, mFallen && (mBit >= S)});
            checkOutput("SD", {31'b0, SD}, {31'b0, expSd()});
            checkOutput("sample_ready", {31'b0, sample_ready}, {31'b0, !mHoldFull});
            checkOutput("frame_start", {31'b0, frame_start}, {31'b0, mFs});
            checkOutput("underrun", {31'b0, underrun}, {31'b0, mUr});
        end
    end

    task automatic applyStimulus(input logic [W-1:0] l, input logic [W-1:0] r, input logic v);
        sample_left = l;
        sample_right = r;
        sample_valid = v;
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus('0, '0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    // Starts right after a frame-load edge; samples SD/WS once per bit count
    task automatic captureFrame(output logic [2*S-1:0] sd, output logic [2*S-1:0] ws);
        for (int k = 0; k < 2 * S; k++) begin
            if (k > 0) repeat (2 * H) @(negedge clk);
            sd[k] = SD;
            ws[k] = WS;
        end
    endtask

    task automatic waitFrameStart(output int edgeAt);
        edgeAt = -1;
        for (int i = 0; i < FRAME + 20; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                edgeAt = tbEdges;
                break;
            end
        end
    endtask

    function automatic logic [W-1:0] leftWord(input logic [2*S-1:0] sd);
        logic [W-1:0] w = '0;
        for (int i = 1; i <= W; i++) w = {w[W-2:0], sd[i]};
        return w;
    endfunction

    function automatic logic [W-1:0] rightWord(input logic [2*S-1:0] sd);
        logic [W-1:0] w = '0;
        for (int i = S + 1; i <= S + W; i++) w = {w[W-2:0], sd[i]};
        return w;
    endfunction

    function automatic int padOnes(input logic [2*S-1:0] sd);
        int n = 0;
        for (int k = 0; k < 2 * S; k++)
            if (!((k >= 1 && k <= W) || (k >= S + 1 && k <= S + W)) && sd[k] !== 1'b0) n++;
        return n;
    endfunction

    initial begin
        // Scenario 1: A5F0/1234 offered at release, serialised in the first frame
        doReset();
        checkEn = 1;
        checkOutput("reset ready", {31'b0, sample_ready}, 32'd1);
        checkOutput("reset SCK", {31'b0, SCK}, 32'd0);
        applyStimulus(16'hA5F0, 16'h1234, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("s1 ready after accept", {31'b0, sample_ready}, 32'd0);
        applyStimulus('0, '0, 1'b0);
        repeat (2 * H - 1) @(negedge clk);
        checkOutput("s1 frame_start", {31'b0, frame_start}, 32'd1);
        checkOutput("s1 underrun", {31'b0, underrun}, 32'd0);
        captureFrame(sdCap, wsCap);
        checkOutput("s1 left word", {16'b0, leftWord(sdCap)}, 32'h0000A5F0);
        checkOutput("s1 right word", {16'b0, rightWord(sdCap)}, 32'h00001234);
        checkOutput("s1 padding", padOnes(sdCap), 32'd0);
        checkOutput("s1 WS left slot", wsCap[S-1:0], 32'h00000000);
        checkOutput("s1 WS right slot", wsCap[2*S-1:S], 32'hFFFFFFFF);
        checkOutput("s1 model frame", {mFrameL, mFrameR}, 32'hA5F01234);

        // Scenario 2: no samples, underrun frames every 640 clk
        doReset();
        reset = 1'b1;
        waitFrameStart(at);
        checkOutput("s2 first load edge", at, 32'd10);
        checkOutput("s2 first underrun", {31'b0, underrun}, 32'd1);
        waitFrameStart(at);
        checkOutput("s2 second load edge", at, 32'd650);
        checkOutput("s2 second underrun", {31'b0, underrun}, 32'd1);
        waitFrameStart(at);
        checkOutput("s2 third load edge", at, 32'd1290);

        // Scenario 3: two pairs back to back, second enters at the cycle after the first load
        doReset();
        applyStimulus(16'hA5F0, 16'h1234, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(16'h0F0F, 16'hC3C3, 1'b1);
        checkOutput("s3 ready after first", {31'b0, sample_ready}, 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("s3 ready before load", {31'b0, sample_ready}, 32'd0);
        @(negedge clk);
        checkOutput("s3 ready after load", {31'b0, sample_ready}, 32'd1);
        checkOutput("s3 load no underrun", {31'b0, underrun}, 32'd0);
        @(negedge clk);
        checkOutput("s3 ready after second", {31'b0, sample_ready}, 32'd0);
        applyStimulus('0, '0, 1'b0);
        repeat (FRAME - 1) @(negedge clk);
        checkOutput("s3 frame1 start", {31'b0, frame_start}, 32'd1);
        captureFrame(sdCap, wsCap);
        checkOutput("s3 frame1 words", {leftWord(sdCap), rightWord(sdCap)}, 32'h0F0FC3C3);

        // Scenario 4: accept exactly in the load cycle underruns; pair goes out next frame
        doReset();
        reset = 1'b1;
        repeat (2 * H - 1) @(negedge clk);
        applyStimulus(16'h5A5A, 16'hA5A5, 1'b1);
        @(negedge clk);
        checkOutput("s4 load underrun", {31'b0, underrun}, 32'd1);
        checkOutput("s4 held after load", {31'b0, sample_ready}, 32'd0);
        applyStimulus('0, '0, 1'b0);
        captureFrame(sdCap, wsCap);
        checkOutput("s4 frame0 silent", $countones(sdCap), 32'd0);
        repeat (2 * H) @(negedge clk);
        checkOutput("s4 frame1 no underrun", {30'b0, frame_start, underrun}, 32'd2);
        captureFrame(sdCap, wsCap);
        checkOutput("s4 frame1 words", {leftWord(sdCap), rightWord(sdCap)}, 32'h5A5AA5A5);

        // Scenario 5: reset in bit count 20 with SCK high and a pair held
        doReset();
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(16'h1111, 16'h2222, 1'b1);
        repeat (10) @(negedge clk);
        applyStimulus('0, '0, 1'b0);
        repeat (204) @(negedge clk);
        checkOutput("s5 SCK before reset", {31'b0, SCK}, 32'd1);
        checkOutput("s5 held before reset", {31'b0, sample_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("s5 reset outputs", {28'b0, SCK, WS, SD, sample_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2 * H) @(negedge clk);
        checkOutput("s5 first frame underrun", {30'b0, frame_start, underrun}, 32'd3);
        captureFrame(sdCap, wsCap);
        checkOutput("s5 first frame silent", $countones(sdCap), 32'd0);

        // Scenario 6: full-scale extremes 8000/7FFF
        doReset();
        applyStimulus(16'h8000, 16'h7FFF, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus('0, '0, 1'b0);
        repeat (2 * H - 1) @(negedge clk);
        captureFrame(sdCap, wsCap);
        checkOutput("s6 left MSB", {31'b0, sdCap[1]}, 32'd1);
        checkOutput("s6 right MSB", {31'b0, sdCap[S+1]}, 32'd0);
        checkOutput("s6 words", {leftWord(sdCap), rightWord(sdCap)}, 32'h80007FFF);
        checkOutput("s6 padding", padOnes(sdCap), 32'd0);

        checkEn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
